// File: rtl/ras_ckpt_pkg.sv
// Shared configuration and checkpoint record for the return-address stack.
// The default stack geometry is defined here; the top can override it with parameters.
package ras_ckpt_pkg;

   // taiga_config
   localparam int RAS_ADDR_W     = 32;
   localparam int RAS_DEPTH      = 8;
   localparam int RAS_CKPT_DEPTH = 4;
   localparam int RAS_DEPTH_W    = $clog2(RAS_DEPTH);

   // taiga_types: the record saved for each in-flight branch, at the default geometry
   typedef struct packed {
      logic [RAS_DEPTH_W-1:0] idx;
      logic [RAS_DEPTH_W:0]   cnt;
      logic [RAS_ADDR_W-1:0]  top;
   } ras_ckpt_t;

   // Pointer width for an N-entry ring, never narrower than one bit
   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ras_ckpt_buffer.sv
// Circular FIFO of branch checkpoints. The head entry is always visible on data_out.
// A synchronous clear takes priority over push and pop, and push+pop on a full FIFO is legal.
module ras_ckpt_buffer
   import ras_ckpt_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             full
);
   localparam int            PW       = ptr_w(DEPTH);
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
   localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign valid    = (cnt_q != '0);
   assign full     = (cnt_q == FULL_CNT);
   assign do_pop   = pop & valid;
   // A full FIFO only accepts a new entry when the head leaves in the same cycle
   assign do_push  = push & (~full | do_pop);
   assign data_out = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
         if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clear && do_push) mem_q[wr_q] <= data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ras_ckpt.sv
// Return-address stack with occupancy tracking and per-branch checkpoints.
// A flush restores pointer, occupancy and the top entry from the oldest checkpoint.
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int ADDR_W     = RAS_ADDR_W,
   parameter int DEPTH      = RAS_DEPTH,
   parameter int CKPT_DEPTH = RAS_CKPT_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] new_addr,
   input  logic              branch_fetched,
   input  logic              branch_retired,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic              ckpt_full,
   output logic              overflow
);
   localparam int                 DEPTH_W  = $clog2(DEPTH);
   localparam logic [DEPTH_W:0]   CNT_FULL = (DEPTH_W + 1)'(DEPTH);

   typedef struct packed {
      logic [DEPTH_W-1:0] idx;
      logic [DEPTH_W:0]   cnt;
      logic [ADDR_W-1:0]  top;
   } ckpt_t;

   logic [ADDR_W-1:0]  ram_q [DEPTH];
   logic [DEPTH_W-1:0] idx_q, idx_d;
   logic [DEPTH_W:0]   cnt_q, cnt_d;
   logic               overflow_q, overflow_d;
   logic               we;
   logic [DEPTH_W-1:0] waddr;
   logic [ADDR_W-1:0]  wdata;
   logic [ADDR_W-1:0]  tos;
   ckpt_t              ck_in, ck_head;
   logic               ck_valid;

   assign tos   = ram_q[idx_q];
   assign ck_in = '{idx: idx_q, cnt: cnt_q, top: tos};

   ras_ckpt_buffer #(
      .WIDTH ($bits(ckpt_t)),
      .DEPTH (CKPT_DEPTH)
   ) u_ckpt_buffer (
      .clk      (clk),
      .rst      (rst),
      .push     (branch_fetched),
      .pop      (branch_retired),
      .clear    (flush),
      .data_in  (ck_in),
      .data_out (ck_head),
      .valid    (ck_valid),
      .full     (ckpt_full)
   );

   always_comb begin
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      overflow_d = 1'b0;
      we         = 1'b0;
      waddr      = idx_q;
      wdata      = new_addr;
      if (flush) begin
         if (ck_valid) begin
            idx_d = ck_head.idx;
            cnt_d = ck_head.cnt;
            we    = 1'b1;
            waddr = ck_head.idx;
            wdata = ck_head.top;
         end
      end else if (push && (!pop || cnt_q == '0)) begin
         // Pushing on a full stack overwrites the oldest entry in place
         idx_d = idx_q + 1'b1;
         we    = 1'b1;
         waddr = idx_q + 1'b1;
         if (cnt_q == CNT_FULL) overflow_d = 1'b1;
         else                   cnt_d      = cnt_q + 1'b1;
      end else if (push && pop) begin
         we = 1'b1;
      end else if (pop && cnt_q != '0) begin
         idx_d = idx_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) ram_q[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q      <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign addr       = (cnt_q == '0) ? '0 : tos;
   assign addr_valid = (cnt_q != '0);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (DEPTH=4, CKPT_DEPTH=4); expected outputs are queued per step.
module tb_ras_ckpt;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0, push = 1'b0, pop = 1'b0;
   logic        branch_fetched = 1'b0, branch_retired = 1'b0;
   logic [31:0] new_addr = '0;
   logic [31:0] addr;
   logic        addr_valid, ckpt_full, overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic        v;
      logic        f;
      logic        o;
      string       tag;
   } exp_t;
   exp_t sb[$];

   ras_ckpt #(.ADDR_W(32), .DEPTH(4), .CKPT_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .push           (push),
      .pop            (pop),
      .new_addr       (new_addr),
      .branch_fetched (branch_fetched),
      .branch_retired (branch_retired),
      .addr           (addr),
      .addr_valid     (addr_valid),
      .ckpt_full      (ckpt_full),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] ea,
                            input logic ev, input logic ef, input logic eo);
      chk({tag, ".addr"}, addr, ea);
      chk({tag, ".addr_valid"}, {31'b0, addr_valid}, {31'b0, ev});
      chk({tag, ".ckpt_full"}, {31'b0, ckpt_full}, {31'b0, ef});
      chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
   endtask

   // Drive one cycle of stimulus, queue its expected result, compare after the edge
   task automatic step(input logic pu, input logic po, input logic [31:0] na,
                       input logic bf, input logic br, input logic fl,
                       input logic [31:0] ea, input logic ev, input logic ef,
                       input logic eo, input string tag);
      exp_t e;
      @(negedge clk);
      push = pu; pop = po; new_addr = na;
      branch_fetched = bf; branch_retired = br; flush = fl;
      e.a = ea; e.v = ev; e.f = ef; e.o = eo; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; branch_fetched = 1'b0;
      branch_retired = 1'b0; flush = 1'b0;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check_out(e.tag, e.a, e.v, e.f, e.o);
      end
      $display("step %s addr=%h valid=%b full=%b ovf=%b", tag, addr, addr_valid, ckpt_full, overflow);
   endtask

   initial begin
      #2 rst = 1'b0;
      #2;
      check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      $display("step reset addr=%h valid=%b full=%b ovf=%b", addr, addr_valid, ckpt_full, overflow);
      @(negedge clk);
      rst = 1'b1;

      //    pu   po   addr      bf   br   fl    exp_addr  v    f    o
      step(1'b1,1'b0,32'h100,  1'b0,1'b0,1'b0, 32'h100, 1'b1,1'b0,1'b0, "push100");
      step(1'b1,1'b0,32'h200,  1'b0,1'b0,1'b0, 32'h200, 1'b1,1'b0,1'b0, "push200");
      step(1'b1,1'b0,32'h300,  1'b0,1'b0,1'b0, 32'h300, 1'b1,1'b0,1'b0, "push300");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h200, 1'b1,1'b0,1'b0, "pop1");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h100, 1'b1,1'b0,1'b0, "pop2");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "pop3");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "pop_empty");

      step(1'b1,1'b0,32'h10,   1'b0,1'b0,1'b0, 32'h10,  1'b1,1'b0,1'b0, "push10");
      step(1'b1,1'b0,32'h20,   1'b0,1'b0,1'b0, 32'h20,  1'b1,1'b0,1'b0, "push20");
      step(1'b1,1'b0,32'h30,   1'b0,1'b0,1'b0, 32'h30,  1'b1,1'b0,1'b0, "push30");
      step(1'b1,1'b0,32'h40,   1'b0,1'b0,1'b0, 32'h40,  1'b1,1'b0,1'b0, "push40");
      step(1'b1,1'b0,32'h50,   1'b0,1'b0,1'b0, 32'h50,  1'b1,1'b0,1'b1, "push50_ovf");
      step(1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0, 32'h50,  1'b1,1'b0,1'b0, "ovf_clear");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h40,  1'b1,1'b0,1'b0, "wrap_pop1");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h30,  1'b1,1'b0,1'b0, "wrap_pop2");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h20,  1'b1,1'b0,1'b0, "wrap_pop3");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "wrap_pop4");

      step(1'b1,1'b0,32'hA0,   1'b0,1'b0,1'b0, 32'hA0,  1'b1,1'b0,1'b0, "pushA0");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'hA0,  1'b1,1'b0,1'b0, "ckpt_A0");
      step(1'b1,1'b1,32'hBB,   1'b0,1'b0,1'b0, 32'hBB,  1'b1,1'b0,1'b0, "wrongpath_BB");
      step(1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'hA0,  1'b1,1'b0,1'b0, "flush_repair");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "pop_after_repair");

      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "bf1");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "bf2");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "bf3");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h0,   1'b0,1'b1,1'b0, "bf4_full");
      step(1'b0,1'b0,32'h0,    1'b1,1'b1,1'b0, 32'h0,   1'b0,1'b1,1'b0, "bf_br_full");
      step(1'b0,1'b0,32'h0,    1'b0,1'b1,1'b0, 32'h0,   1'b0,1'b0,1'b0, "br_alone");
      step(1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h0,   1'b0,1'b0,1'b0, "flush_clear");

      step(1'b1,1'b0,32'h40,   1'b0,1'b0,1'b0, 32'h40,  1'b1,1'b0,1'b0, "push40b");
      step(1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h40,  1'b1,1'b0,1'b0, "flush_empty");
      step(1'b1,1'b0,32'h77,   1'b0,1'b0,1'b1, 32'h40,  1'b1,1'b0,1'b0, "flush_push77");
      step(1'b1,1'b0,32'h55,   1'b0,1'b0,1'b0, 32'h55,  1'b1,1'b0,1'b0, "push55");
      step(1'b1,1'b0,32'h66,   1'b0,1'b0,1'b0, 32'h66,  1'b1,1'b0,1'b0, "push66");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h66,  1'b1,1'b0,1'b0, "bfa");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h66,  1'b1,1'b0,1'b0, "bfb");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h66,  1'b1,1'b0,1'b0, "bfc");
      step(1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0, 32'h66,  1'b1,1'b1,1'b0, "bfd_full");

      #2 rst = 1'b0;
      #1;
      check_out("midreset", 32'h0, 1'b0, 1'b0, 1'b0);
      $display("step midreset addr=%h valid=%b full=%b ovf=%b", addr, addr_valid, ckpt_full, overflow);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1,1'b0,32'h99,   1'b0,1'b0,1'b0, 32'h99,  1'b1,1'b0,1'b0, "push99");
      step(1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0, 32'h0,   1'b0,1'b0,1'b0, "pop99");

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Parametrised return-address stack (RAS) for the fetch stage.
- Generalises the existing stack in four ways: configurable address width, configurable depth, a tracked occupancy with an empty indication, and a richer checkpoint per in-flight branch.
- Each checkpoint stores the top-of-stack (TOS) index, the occupancy and the TOS entry value, so a flush repairs both the pointer and a wrong-path overwrite of the top entry.
- Sits beside the branch predictor: fetch drives push/pop, the branch unit drives retire, and global control drives flush.

Parameters:
- ADDR_W, 32, width of the stored return address.
- DEPTH, 8, number of stack entries; power of two, at least 2.
- CKPT_DEPTH, 4, maximum in-flight branch checkpoints (MAX_IDS in system use); power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  misprediction flush (gc_fetch_flush); restores state from the oldest checkpoint.
- push  in  1  call fetched; push new_addr.
- pop  in  1  return fetched; pop the TOS entry.
- new_addr  in  ADDR_W  return address to push.
- branch_fetched  in  1  speculative branch fetched; capture a checkpoint.
- branch_retired  in  1  oldest branch resolved correctly; drop its checkpoint.
- addr  out  ADDR_W  predicted return address (current TOS entry).
- addr_valid  out  1  occupancy is non-zero.
- ckpt_full  out  1  checkpoint buffer holds CKPT_DEPTH entries; fetch must stall branches.
- overflow  out  1  single-cycle pulse: a push occurred while occupancy was DEPTH.

Behaviour:
- State:
  - idx, DEPTH_W bits: TOS index.
  - cnt, DEPTH_W+1 bits: occupancy, 0..DEPTH.
  - Entry RAM: DEPTH x ADDR_W, not reset.
  - Checkpoint FIFO.
- Reset (async assert, sync release): idx=0, cnt=0, checkpoint FIFO empty, addr=0, addr_valid=0, ckpt_full=0, overflow=0.
- addr is combinational from registered state: addr = 0 when cnt==0, otherwise ram[idx]. Updates are visible the cycle after the causing event.
- Push only: idx <= idx+1 (modulo DEPTH); ram[idx+1] <= new_addr; cnt <= min(cnt+1, DEPTH).
  - If cnt was DEPTH, the oldest entry is overwritten and overflow pulses for one cycle.
- Pop only:
  - When cnt>0: idx <= idx-1 (modulo DEPTH); cnt <= cnt-1.
  - When cnt==0: no state change.
- Push and pop in the same cycle: ram[idx] <= new_addr; idx and cnt are unchanged.
  - On an empty stack this is treated as a push (cnt becomes 1, idx+1 written).
- Checkpoint capture on branch_fetched: pushes {idx, cnt, ram[idx]}.
  - The captured value is the state before any same-cycle push/pop.
  - If the FIFO is full and there is no same-cycle retire, the capture is dropped; ckpt_full already warned fetch.
- branch_retired pops the FIFO head. Retire on an empty FIFO is ignored.
- Fetch and retire in the same cycle on a full FIFO: both are honoured, and occupancy is unchanged.
- Flush (highest priority):
  - If the FIFO is non-empty: idx <= head.idx; cnt <= head.cnt; ram[head.idx] <= head.top.
  - If the FIFO is empty: idx, cnt and RAM are unchanged.
  - In both cases the FIFO is cleared, and push, pop, branch_fetched and branch_retired in the same cycle are ignored.
- Reset mid-operation: all state returns to reset values immediately; RAM contents remain stale but are masked by cnt==0.
- Widths: idx arithmetic wraps modulo DEPTH. cnt saturates at DEPTH and at 0, with no wrap.

Decomposition:
- Package items:
  - taiga_config: RAS_DEPTH and RAS_CKPT_DEPTH.
  - taiga_types: the packed typedef ras_ckpt_t {idx, cnt, top}.
- One sub-module, ras_ckpt_buffer:
  - Circular FIFO of ras_ckpt_t with async active-low reset and synchronous clear.
  - Ports: push, pop, clear, data_in, data_out (head), valid, full.
  - Simultaneous push+pop on full is legal.
- Top level:
  - Pointer and occupancy logic, the entry RAM as a distributed/LUT-RAM array with one write port, and the priority mux (flush > push/pop).

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> addr=0x300, addr_valid=1; three pops -> 0x200, 0x100, then addr=0, addr_valid=0; a fourth pop leaves cnt=0.
- DEPTH=4: push 0x10..0x50 -> overflow pulses on the 5th push only; then 4 pops return 0x50, 0x40, 0x30, 0x20, after which addr_valid=0.
- Push 0xA0, then branch_fetched, then a wrong-path pop+push of 0xBB, then flush -> next cycle addr=0xA0 and cnt=1 (top entry repaired).
- CKPT_DEPTH=4: four branch_fetched -> ckpt_full=1; fetch and retire in the same cycle -> ckpt_full stays 1; a retire alone -> ckpt_full=0.
- Push 0x40 with the checkpoint FIFO empty, then flush -> addr=0x40, unchanged; flush with a same-cycle push of 0x77 -> the push is ignored.
- Assert rst mid-sequence (cnt=3) -> addr=0, addr_valid=0, ckpt_full=0 before the next clock edge.
